// File: rtl/vc_credit_tx_pkg.sv
// vc_credit_tx shared types and field layout.
// Credit words reuse the flit field positions.
package vc_credit_tx_pkg;

  localparam int FLIT_W  = 22;
  localparam int VC_W    = 5;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = VC_W + DATA_W;

  typedef struct packed {
    logic              valid;
    logic [VC_W-1:0]   vc;
    logic [DATA_W-1:0] data;
  } flit_t;

  function automatic logic vc_ok(
    input logic [VC_W-1:0] vc,
    input int              n
  );
    return int'(vc) < n;
  endfunction

endpackage

// File: rtl/vc_credit_tx_if.sv
// Switch-side and link-side bundle of vc_credit_tx.
// master drives flits and credits, slave is the tx port.
interface vc_credit_tx_if
  import vc_credit_tx_pkg::*;
#(
  parameter int NUM_VCS = 4
);

  flit_t              in_flit;
  logic [NUM_VCS-1:0] in_ready;
  flit_t              cr_in;
  flit_t              out_flit;
  logic               idle;
  logic               err_credit;

  modport master (
    output in_flit,
    output cr_in,
    input  in_ready,
    input  out_flit,
    input  idle,
    input  err_credit
  );

  modport slave (
    input  in_flit,
    input  cr_in,
    output in_ready,
    output out_flit,
    output idle,
    output err_credit
  );

endinterface

// File: rtl/vc_flit_fifo.sv
// Per-VC flit queue, single clock.
// Pointers carry one extra bit to tell full from empty.
module vc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq_i,
  input  logic [W-1:0] data_i,
  input  logic         deq_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push, pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign push = enq_i && !full_o;
  assign pop  = deq_i && !empty_o;

  // Next pointer values.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + (AW+1)'(1);
    if (pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/vc_credit_tx.sv
// Credit-based link transmitter for one router output.
// Per-VC queues, per-VC credit counters, round-robin send.
module vc_credit_tx
  import vc_credit_tx_pkg::*;
#(
  parameter int NUM_VCS   = 4,
  parameter int BUF_DEPTH = 8,
  parameter int QDEPTH    = 4
) (
  input logic           clk,
  input logic           rst_n,
  vc_credit_tx_if.slave bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BUF_DEPTH);

  flit_t              fin;
  logic               fin_ok;
  logic               cr_v;
  logic [VC_W-1:0]    cr_vc;
  logic               cr_ok;
  logic               unused_cr_stamp;

  logic [NUM_VCS-1:0] enq, deq, full, empty, elig;
  logic [ENTRY_W-1:0] head [NUM_VCS];

  logic [CW-1:0]      cred_q [NUM_VCS];
  logic [CW-1:0]      cred_d [NUM_VCS];
  logic [PW-1:0]      ptr_q, ptr_d;
  flit_t              out_q, out_d;
  logic               err_q, err_d;

  logic               gnt_vld;
  logic [PW-1:0]      gnt_idx;
  logic               ovf;

  assign fin    = bus.in_flit;
  assign fin_ok = vc_ok(fin.vc, NUM_VCS);
  assign cr_v   = bus.cr_in.valid;
  assign cr_vc  = bus.cr_in.vc;
  assign cr_ok  = vc_ok(cr_vc, NUM_VCS);

  assign unused_cr_stamp = ^bus.cr_in.data;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign enq[v] = fin.valid && fin_ok &&
                    (fin.vc == VC_W'(v)) && !full[v];
    assign elig[v] = !empty[v] && (cred_q[v] != '0);
    assign deq[v] = gnt_vld && (gnt_idx == PW'(v));

    vc_flit_fifo #(
      .DEPTH (QDEPTH),
      .W     (ENTRY_W)
    ) u_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .enq_i   (enq[v]),
      .data_i  ({fin.vc, fin.data}),
      .deq_i   (deq[v]),
      .full_o  (full[v]),
      .empty_o (empty[v]),
      .head_o  (head[v])
    );
  end

  assign bus.in_ready   = ~full;
  assign bus.out_flit   = out_q;
  assign bus.err_credit = err_q;

  // Round-robin pick, scanning from the VC after the last winner.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NUM_VCS; i++) begin
      j = (int'(ptr_q) + i) % NUM_VCS;
      if (!gnt_vld && elig[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  // Credit update, sticky error and link output next state.
  always_comb begin
    logic inc;
    inc   = 1'b0;
    ovf   = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      cred_d[v] = cred_q[v];
      inc = cr_v && cr_ok && (cr_vc == VC_W'(v));
      if (inc && !deq[v]) begin
        if (cred_q[v] == CMAX) ovf = 1'b1;
        else cred_d[v] = cred_q[v] + CW'(1);
      end else if (deq[v] && !inc) begin
        cred_d[v] = cred_q[v] - CW'(1);
      end
    end
    err_d = err_q | ovf |
            (fin.valid && !fin_ok) |
            (cr_v && !cr_ok);
    ptr_d = gnt_vld ? gnt_idx : ptr_q;
    out_d = '0;
    if (gnt_vld) out_d = {1'b1, head[gnt_idx]};
  end

  // Idle when nothing is queued and every credit is home.
  always_comb begin
    bus.idle = 1'b1;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (!empty[v] || cred_q[v] != CMAX) bus.idle = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= CMAX;
      ptr_q <= PW'(NUM_VCS - 1);
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= cred_d[v];
      ptr_q <= ptr_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_vc_credit_tx.sv
// Self-checking bench for vc_credit_tx.
// Vector table plus scoreboarded multi-cycle sequences.
`timescale 1ns/1ps
module tb_vc_credit_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vc_credit_tx_if #(.NUM_VCS(4)) bus ();

  vc_credit_tx #(
    .NUM_VCS   (4),
    .BUF_DEPTH (8),
    .QDEPTH    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;
  int vout = 0;
  logic sb_on = 1'b0;
  logic [21:0] sb [$];

  typedef struct {
    logic [21:0] fl;
    logic [21:0] cr;
    logic [21:0] eout;
    logic        eidle;
    logic        eerr;
    string       nm;
  } vec_t;

  vec_t vt [8];

  function automatic logic [21:0] fl(
    input logic [4:0] vc, input logic [15:0] d);
    return {1'b1, vc, d};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [21:0] e;
    @(posedge clk);
    #1;
    if (bus.out_flit.valid) vout++;
    if (sb_on && bus.out_flit.valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'(bus.out_flit), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("sb_flit", 32'(bus.out_flit), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_flit = '0;
    bus.cr_in = '0;
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_flits(input logic [4:0] vc, input int n,
                            input logic [15:0] base,
                            input int npush);
    int k;
    int guard;
    logic rdy;
    k = 0;
    guard = 0;
    while (k < n && guard < 500) begin
      bus.in_flit = fl(vc, base + 16'(k));
      rdy = bus.in_ready[vc];
      tick();
      if (rdy) begin
        if (k < npush) sb.push_back(fl(vc, base + 16'(k)));
        k++;
      end
      guard++;
    end
    if (k < n) chk("send_timeout", 32'(k), 32'(n));
    bus.in_flit = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{22'h0, 22'h0, 22'h0, 1'b1, 1'b0, "none"};
    vt[1] = '{22'h0, fl(0, 0), 22'h0, 1'b1, 1'b1, "cr_ovf"};
    vt[2] = '{22'h0, fl(7, 0), 22'h0, 1'b1, 1'b1, "cr_vc7"};
    vt[3] = '{22'h0, fl(4, 0), 22'h0, 1'b1, 1'b1, "cr_vc4"};
    vt[4] = '{fl(5, 16'h1234), 22'h0, 22'h0, 1'b1, 1'b1, "fl_vc5"};
    vt[5] = '{fl(2, 16'hBEEF), 22'h0, fl(2, 16'hBEEF),
              1'b0, 1'b0, "fl_vc2"};
    vt[6] = '{fl(3, 16'h0033), fl(3, 0), fl(3, 16'h0033),
              1'b0, 1'b1, "fl_cr3"};
    vt[7] = '{{1'b0, 5'd5, 16'h5555}, 22'h0, 22'h0,
              1'b1, 1'b0, "fl_inv"};

    bus.in_flit = '0;
    bus.cr_in = '0;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out", 32'(bus.out_flit), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'hF);
    chk("rst_idle", 32'(bus.idle), 32'h1);
    chk("rst_err", 32'(bus.err_credit), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_out", 32'(bus.out_flit), 32'h0);
    chk("post_ready", 32'(bus.in_ready), 32'hF);
    chk("post_idle", 32'(bus.idle), 32'h1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.in_flit = vt[i].fl;
      bus.cr_in = vt[i].cr;
      tick();
      bus.in_flit = '0;
      bus.cr_in = '0;
      tick();
      chk({vt[i].nm, "_out"}, 32'(bus.out_flit), 32'(vt[i].eout));
      chk({vt[i].nm, "_idle"}, 32'(bus.idle), 32'(vt[i].eidle));
      chk({vt[i].nm, "_err"}, 32'(bus.err_credit), 32'(vt[i].eerr));
    end

    sb_on = 1'b1;

    do_reset();
    bus.in_flit = fl(0, 0);
    sb.push_back(fl(0, 0));
    tick();
    chk("lat_first", 32'(bus.out_flit), 32'h0);
    bus.in_flit = fl(0, 1);
    sb.push_back(fl(0, 1));
    tick();
    chk("lat_second", 32'(bus.out_flit), 32'(fl(0, 0)));
    send_flits(5'd0, 8, 16'd2, 6);
    repeat (10) tick();
    chk("exh_sb", 32'(sb.size()), 32'h0);
    chk("exh_out", 32'(bus.out_flit), 32'h0);
    chk("exh_idle", 32'(bus.idle), 32'h0);
    bus.cr_in = fl(0, 0);
    sb.push_back(fl(0, 8));
    tick();
    bus.cr_in = '0;
    chk("cr_k", 32'(bus.out_flit), 32'h0);
    tick();
    chk("cr_k1", 32'(bus.out_flit), 32'(fl(0, 8)));
    sb.push_back(fl(0, 9));
    bus.cr_in = fl(0, 0);
    repeat (9) tick();
    bus.cr_in = '0;
    repeat (2) tick();
    chk("refill_sb", 32'(sb.size()), 32'h0);
    chk("refill_idle", 32'(bus.idle), 32'h1);
    chk("refill_err", 32'(bus.err_credit), 32'h0);
    bus.cr_in = fl(0, 0);
    tick();
    bus.cr_in = '0;
    chk("ovf_err", 32'(bus.err_credit), 32'h1);
    chk("ovf_idle", 32'(bus.idle), 32'h1);
    repeat (3) tick();
    chk("ovf_sticky", 32'(bus.err_credit), 32'h1);

    do_reset();
    vout = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_flit = fl((i % 2) ? 5'd2 : 5'd0, 16'(16'h200 + i));
      sb.push_back(bus.in_flit);
      tick();
    end
    bus.in_flit = '0;
    tick();
    chk("rr_sb", 32'(sb.size()), 32'h0);
    chk("rr_nogap", 32'(vout), 32'd6);

    do_reset();
    send_flits(5'd1, 7, 16'h100, 7);
    repeat (5) tick();
    chk("sim_drain", 32'(sb.size()), 32'h0);
    bus.in_flit = fl(1, 16'h1A);
    sb.push_back(fl(1, 16'h1A));
    tick();
    bus.in_flit = fl(1, 16'h1B);
    bus.cr_in = fl(1, 0);
    sb.push_back(fl(1, 16'h1B));
    tick();
    bus.in_flit = '0;
    bus.cr_in = '0;
    tick();
    chk("sim_again", 32'(bus.out_flit), 32'(fl(1, 16'h1B)));
    tick();
    chk("sim_stall", 32'(bus.out_flit), 32'h0);
    bus.in_flit = fl(1, 16'h1C);
    tick();
    bus.in_flit = '0;
    repeat (3) tick();
    chk("sim_stall2", 32'(bus.out_flit), 32'h0);
    chk("sim_idle", 32'(bus.idle), 32'h0);

    do_reset();
    send_flits(5'd3, 8, 16'h300, 8);
    repeat (4) tick();
    send_flits(5'd3, 4, 16'h3F0, 0);
    tick();
    chk("bp_ready", 32'(bus.in_ready), 32'h7);
    bus.in_flit = fl(3, 16'h3F4);
    repeat (2) tick();
    chk("bp_hold", 32'(bus.in_ready), 32'h7);
    bus.in_flit = '0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(fl(3, 16'(16'h3F0 + i)));
      bus.cr_in = fl(3, 0);
      tick();
      bus.cr_in = '0;
      tick();
    end
    chk("bp_sb", 32'(sb.size()), 32'h0);
    chk("bp_ready2", 32'(bus.in_ready), 32'hF);
    bus.cr_in = fl(3, 0);
    tick();
    bus.cr_in = '0;
    repeat (2) tick();
    chk("bp_no5th", 32'(bus.out_flit), 32'h0);
    chk("bp_idle", 32'(bus.idle), 32'h0);
    bus.in_flit = fl(3, 16'h3F5);
    sb.push_back(fl(3, 16'h3F5));
    tick();
    bus.in_flit = '0;
    tick();
    chk("mr_pre", 32'(bus.out_flit), 32'(fl(3, 16'h3F5)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out", 32'(bus.out_flit), 32'h0);
    chk("mr_ready", 32'(bus.in_ready), 32'hF);
    chk("mr_idle", 32'(bus.idle), 32'h1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mr_after", 32'(bus.out_flit), 32'h0);
    chk("mr_idle2", 32'(bus.idle), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
